rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Register-file write-back arbiter. Round-robin by default; define
//            WB_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rfwe,
  output logic [4:0]            rfwa,
  output logic [31:0]           rfwd,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]     r_ptr;
  logic                 r_we;
  logic [4:0]           r_wa;
  logic [31:0]          r_wd;
  logic [CNT_W-1:0]     r_cnt;

  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_oh;
  logic                 w_found;
  logic [2*NUM_REQ-1:0] w_gnt2;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_xfer;
  logic                 w_multi;
  logic [4:0]           w_sel_addr;
  logic [31:0]          w_sel_data;
  logic [4:0]           w_addr_arr [NUM_REQ];
  logic [31:0]          w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*5 +: 5];
    assign w_data_arr[g] = req_data[g*32 +: 32];
  end

  // Rotate valids so the pointer sits at bit 0, pick the lowest set bit,
  // then rotate the one-hot grant back by folding the doubled vector.
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_ptr);

  always_comb begin
    w_rot_oh = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_rot_oh[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign w_gnt2    = {{NUM_REQ{1'b0}}, w_rot_oh} << r_ptr;
  assign w_gnt     = cpu_rst ? '0 : (w_gnt2[NUM_REQ-1:0] | w_gnt2[2*NUM_REQ-1:NUM_REQ]);
  assign req_ready = w_gnt;
  assign w_xfer    = |(w_gnt & req_valid);
  assign w_multi   = |(req_valid & (req_valid - {{(NUM_REQ-1){1'b0}}, 1'b1}));

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_addr_arr[i];
        w_sel_data = w_data_arr[i];
      end
    end
  end

`ifndef WB_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] w_ptr_nxt;

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end
`endif

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_ptr <= '0;
      r_we  <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
      r_cnt <= '0;
    end else begin
`ifdef WB_ARB_FIXED_PRIO_EN
      r_ptr <= '0;
`else
      r_ptr <= w_ptr_nxt;
`endif
      // Address 0 is a NOP: consumed as a transfer but never written.
      r_we  <= w_xfer && (w_sel_addr != 5'd0);
      r_wa  <= (w_sel_addr != 5'd0) ? w_sel_addr : 5'd0;
      r_wd  <= (w_sel_addr != 5'd0) ? w_sel_data : 32'd0;
      if (w_multi && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rfwe         = r_we;
  assign rfwa         = r_wa;
  assign rfwd         = r_wd;
  assign conflict_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed vector bench for rf_wb_arbiter (round-robin build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [14:0] addr;
  logic [95:0] data;

  logic [2:0]  ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [15:0] cnt;

  logic [2:0]  ready4;
  logic        we4;
  logic [4:0]  wa4;
  logic [31:0] wd4;
  logic [3:0]  cnt4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .req_valid   (valid),
    .req_addr    (addr),
    .req_data    (data),
    .req_ready   (ready),
    .rfwe        (we),
    .rfwa        (wa),
    .rfwd        (wd),
    .conflict_cnt(cnt)
  );

  rf_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut4 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .req_valid   (valid),
    .req_addr    (addr),
    .req_data    (data),
    .req_ready   (ready4),
    .rfwe        (we4),
    .rfwa        (wa4),
    .rfwd        (wd4),
    .conflict_cnt(cnt4)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [14:0] a,
                              input logic [95:0] d, input logic [2:0] rd, input logic e,
                              input logic [4:0] w, input logic [31:0] x, input logic [15:0] c);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = a; t.data = d;
    t.ready = rd; t.we = e; t.wa = w; t.wd = x; t.cnt = c;
    return t;
  endfunction

  initial begin
    logic [14:0] A;
    logic [95:0] D;
    A = {5'd3, 5'd2, 5'd1};
    D = {32'h30, 32'h20, 32'h10};

    // Expected outputs are those visible during the step (result of the previous step's grant).
    vecs[0]  = mk(1, 3'b000, A, D, 3'b000, 0, 0, 32'h0, 0);
    vecs[1]  = mk(0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 0, 0, 32'h0, 0);
    vecs[2]  = mk(0, 3'b000, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b000, 1, 5, 32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 3'b111, A, D, 3'b000, 0, 0, 32'h0, 0);
    vecs[4]  = mk(0, 3'b111, A, D, 3'b001, 0, 0, 32'h0, 0);
    vecs[5]  = mk(0, 3'b111, A, D, 3'b010, 1, 1, 32'h10, 1);
    vecs[6]  = mk(0, 3'b111, A, D, 3'b100, 1, 2, 32'h20, 2);
    vecs[7]  = mk(0, 3'b111, A, D, 3'b001, 1, 3, 32'h30, 3);
    vecs[8]  = mk(0, 3'b111, A, D, 3'b010, 1, 1, 32'h10, 4);
    vecs[9]  = mk(0, 3'b111, A, D, 3'b100, 1, 2, 32'h20, 5);
    vecs[10] = mk(0, 3'b000, A, D, 3'b000, 1, 3, 32'h30, 6);
    vecs[11] = mk(0, 3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 3'b010, 0, 0, 32'h0, 6);
    vecs[12] = mk(0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 3'b100, 1, 4, 32'h44, 6);
    vecs[13] = mk(0, 3'b101, {5'd9, 5'd0, 5'd8}, {32'h90, 32'h0, 32'h80}, 3'b001, 0, 0, 32'h0, 6);
    vecs[14] = mk(0, 3'b100, {5'd9, 5'd0, 5'd8}, {32'h90, 32'h0, 32'h80}, 3'b100, 1, 8, 32'h80, 7);
    vecs[15] = mk(0, 3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h2, 32'h1}, 3'b001, 1, 9, 32'h90, 7);
    vecs[16] = mk(0, 3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h2, 32'h1}, 3'b010, 1, 7, 32'h1, 8);
    vecs[17] = mk(0, 3'b000, A, D, 3'b000, 1, 7, 32'h2, 8);
    vecs[18] = mk(0, 3'b001, A, D, 3'b001, 0, 0, 32'h0, 8);
    vecs[19] = mk(1, 3'b111, A, D, 3'b000, 1, 1, 32'h10, 8);
    vecs[20] = mk(0, 3'b111, A, D, 3'b001, 0, 0, 32'h0, 0);
    vecs[21] = mk(0, 3'b000, A, D, 3'b000, 1, 1, 32'h10, 1);

    rst = 1'b1; valid = '0; addr = '0; data = '0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; valid = vecs[i].valid; addr = vecs[i].addr; data = vecs[i].data;
      @(negedge clk);
      check("ready", i, {29'd0, ready}, {29'd0, vecs[i].ready});
      check("rfwe",  i, {31'd0, we},    {31'd0, vecs[i].we});
      check("rfwa",  i, {27'd0, wa},    {27'd0, vecs[i].wa});
      check("rfwd",  i, wd,             vecs[i].wd);
      check("cnt",   i, {16'd0, cnt},   {16'd0, vecs[i].cnt});
      @(posedge clk); #1;
    end

    // Saturation of the 4-bit counter with two requesters held valid.
    rst = 1'b1; valid = 3'b011; addr = A; data = D;
    @(negedge clk);
    check("rst_ready", 0, {29'd0, ready4}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("cnt4", k, {28'd0, cnt4}, (k > 15) ? 32'd15 : k);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("cnt4_end", 20, {28'd0, cnt4}, 32'd15);
    check("cnt16_end", 20, {16'd0, cnt}, 32'd20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
